spi_slv_regbus: RTL

//  Parametrised SPI (mode 0) slave to register-bus bridge; successor of the fixed 16-bit 8b8b slave.

---
 rtl/spi_slv_regbus.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_slv_regbus.sv
// SPI mode-0 slave to register-bus bridge: 8-bit command, AW-bit address, burst of DW-bit words.
// Define SPI_SLV_REGBUS_STATUS_EN to shift sticky status {4'hA,2'b00,rd_late,abort} out during CMD.
//
// state | meaning
// IDLE  | chip select high, waiting for CS fall
// CMD   | shifting in the 8-bit command byte
// ADDR  | shifting in the AW-bit register address
// DATA  | burst of DW-bit words, write or read by command bit 7
module spi_slv_regbus #(
  parameter int AW   = 12,
  parameter int DW   = 8,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          spi_clk,
  input  logic          spi_en_n,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] adr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  input  logic          rd_valid,
  output logic          busy
);

  localparam int IW = (AW > DW) ? ((AW > 8) ? AW : 8) : ((DW > 8) ? DW : 8);
  localparam int BW = $clog2(IW);

  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

  state_t        state, state_nxt;
  logic [SYNC-1:0] sck_sync, cs_sync, mosi_sync;
  logic          sck_d, cs_d;
  logic          sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
  logic [BW-1:0] bit_left;
  logic          bit_last, word_done;
  logic [IW-1:0] sh_in, shifted;
  logic          cmd_wr, cmd_inc;
  logic          rd_go, inc_pend, rd_wait, rd_have, rd_load;
  logic [DW-1:0] rd_buf, rd_sh;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC-2:0], spi_en_n};
      mosi_sync <= {mosi_sync[SYNC-2:0], spi_mosi};
      sck_d     <= sck_sync[SYNC-1];
      cs_d      <= cs_sync[SYNC-1];
    end
  end

  assign sck_rise  = sck_sync[SYNC-1] & ~sck_d;
  assign sck_fall  = ~sck_sync[SYNC-1] & sck_d;
  assign cs_fall   = ~cs_sync[SYNC-1] & cs_d;
  assign cs_rise   = cs_sync[SYNC-1] & ~cs_d;
  assign mosi_s    = mosi_sync[SYNC-1];
  assign bit_last  = (bit_left == '0);
  assign word_done = sck_rise && bit_last;
  assign shifted   = {sh_in[IW-2:0], mosi_s};
  assign rd_load   = sck_fall && (state == DATA) && !cmd_wr && (bit_left == BW'(DW-1));

`ifdef SPI_SLV_REGBUS_STATUS_EN
  logic          rd_late, abort, partial;
  logic [7:0]    st_sh;
  logic [BW-1:0] bit_full;

  always_comb begin
    bit_full = BW'(DW-1);
    case (state)
      CMD:     bit_full = BW'(7);
      ADDR:    bit_full = BW'(AW-1);
      default: ;
    endcase
  end

  // A rise landing on the last bit completes the word, so it is not a partial one.
  assign partial = (state != IDLE) && (sck_rise ? !bit_last : (bit_left != bit_full));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_late <= 1'b0;
      abort   <= 1'b0;
      st_sh   <= '0;
    end else if (cs_fall) begin
      st_sh   <= {4'hA, 2'b00, rd_late, abort};
      rd_late <= 1'b0;
      abort   <= 1'b0;
    end else begin
      if (sck_fall && (state == CMD)) st_sh <= {st_sh[6:0], 1'b0};
      if (cs_rise && partial) abort <= 1'b1;
      if (rd_load && !rd_have) rd_late <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_nxt = CMD;
        CMD:     if (word_done) state_nxt = ADDR;
        ADDR:    if (word_done) state_nxt = DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    spi_miso = 1'b0;
    case (state)
      CMD: begin
`ifdef SPI_SLV_REGBUS_STATUS_EN
        spi_miso = st_sh[7];
`endif
      end
      DATA:    if (!cmd_wr) spi_miso = rd_sh[DW-1];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bit_left <= '0;
      sh_in    <= '0;
      cmd_wr   <= 1'b0;
      cmd_inc  <= 1'b0;
      adr      <= '0;
      wdata    <= '0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      rd_go    <= 1'b0;
      inc_pend <= 1'b0;
      rd_wait  <= 1'b0;
      rd_have  <= 1'b0;
      rd_buf   <= '0;
      rd_sh    <= '0;
    end else begin
      wr_en    <= 1'b0;
      rd_en    <= rd_go;
      rd_go    <= 1'b0;
      inc_pend <= 1'b0;
      if (inc_pend) adr <= adr + AW'(1);
      // A new request drops any stale read data still held from the previous one.
      if (rd_go) begin
        rd_have <= 1'b0;
        rd_wait <= 1'b1;
      end else if (rd_wait && rd_valid) begin
        rd_buf  <= rdata;
        rd_have <= 1'b1;
        rd_wait <= 1'b0;
      end
      if (cs_fall) begin
        bit_left <= BW'(7);
        rd_sh    <= '0;
      end
      if (sck_rise && (state != IDLE)) begin
        sh_in <= shifted;
        if (!bit_last) begin
          bit_left <= bit_left - BW'(1);
        end else begin
          case (state)
            CMD: begin
              cmd_wr   <= shifted[7];
              cmd_inc  <= shifted[6];
              bit_left <= BW'(AW-1);
            end
            ADDR: begin
              adr      <= shifted[AW-1:0];
              rd_go    <= ~cmd_wr;
              bit_left <= BW'(DW-1);
            end
            default: begin
              bit_left <= BW'(DW-1);
              if (cmd_wr) begin
                wr_en    <= 1'b1;
                wdata    <= shifted[DW-1:0];
                inc_pend <= cmd_inc;
              end else begin
                if (cmd_inc) adr <= adr + AW'(1);
                rd_go <= 1'b1;
              end
            end
          endcase
        end
      end
      if (rd_load) begin
        rd_sh   <= rd_have ? rd_buf : '0;
        rd_have <= 1'b0;
      end else if (sck_fall && (state == DATA) && !cmd_wr) begin
        rd_sh <= {rd_sh[DW-2:0], 1'b0};
      end
    end
  end

endmodule
